// File: rtl/rv_decode_stage_if.sv
// Fetch-to-execute handshake bundle for the decode stage: input side, output
// control bundle and the redirect flush.
interface rv_decode_stage_if #(
  parameter int REG_AW = 5,
  parameter int XLEN   = 32
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_inst;
  logic [XLEN-1:0]   in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic [REG_AW-1:0] out_rd;
  logic [REG_AW-1:0] out_rs1;
  logic [REG_AW-1:0] out_rs2;
  logic [31:0]       out_imm;
  logic [3:0]        out_alu_op;
  logic [2:0]        out_lsu_op;
  logic [2:0]        out_br_op;
  logic              out_reg_write;
  logic              out_mem_read;
  logic              out_mem_write;
  logic              out_branch;
  logic              out_jal;
  logic              out_jalr;
  logic              out_alu_src;
  logic              out_pc_src;
  logic              out_illegal;

  modport master (
    output flush, in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_imm,
           out_alu_op, out_lsu_op, out_br_op, out_reg_write, out_mem_read,
           out_mem_write, out_branch, out_jal, out_jalr, out_alu_src,
           out_pc_src, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_imm,
           out_alu_op, out_lsu_op, out_br_op, out_reg_write, out_mem_read,
           out_mem_write, out_branch, out_jal, out_jalr, out_alu_src,
           out_pc_src, out_illegal
  );
endinterface

// File: rtl/rv_decode_stage.sv
// Registered RV32I/RV32E decode stage: combinational decode of the incoming
// word, pushed into a small FIFO whose head drives the execute-side bundle.
module rv_decode_stage #(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 2,
  parameter int XLEN   = 32
) (
  input  logic         clk,
  input  logic         rst,
  rv_decode_stage_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [2:0] LSU_NONE = 3'b111;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [31:0]       imm;
    logic [3:0]        alu_op;
    logic [2:0]        lsu_op;
    logic [2:0]        br_op;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              branch;
    logic              jal;
    logic              jalr;
    logic              alu_src;
    logic              pc_src;
    logic              illegal;
  } entry_t;

  function automatic logic [3:0] f3_alu(input logic [2:0] f3);
    case (f3)
      3'b000:  f3_alu = ALU_ADD;
      3'b001:  f3_alu = ALU_SLL;
      3'b010:  f3_alu = ALU_SLT;
      3'b011:  f3_alu = ALU_SLTU;
      3'b100:  f3_alu = ALU_XOR;
      3'b101:  f3_alu = ALU_SRL;
      3'b110:  f3_alu = ALU_OR;
      default: f3_alu = ALU_AND;
    endcase
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    ptr_inc = (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  logic [31:0] inst;
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

  assign inst   = bus.in_inst;
  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign f7     = inst[31:25];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'b0};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  assign imm_sh = {27'b0, inst[24:20]};

  entry_t dec_next;
  logic   illegal_next;
  logic   use_rd, use_rs1, use_rs2;

  always_comb begin
    dec_next        = '0;
    dec_next.alu_op = ALU_ADD;
    dec_next.lsu_op = LSU_NONE;
    dec_next.pc     = bus.in_pc;
    dec_next.rd     = inst[7 +: REG_AW];
    dec_next.rs1    = inst[15 +: REG_AW];
    dec_next.rs2    = inst[20 +: REG_AW];
    illegal_next    = 1'b0;
    use_rd          = 1'b0;
    use_rs1         = 1'b0;
    use_rs2         = 1'b0;
    case (opcode)
      OP_REG: begin
        use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        dec_next.reg_write = 1'b1;
        dec_next.alu_op    = f3_alu(f3);
        if ((f3 == 3'b000 || f3 == 3'b101) && f7 == F7_ALT)
          dec_next.alu_op = (f3 == 3'b000) ? ALU_SUB : ALU_SRA;
        else if (f7 != 7'b0)
          illegal_next = 1'b1;
      end
      OP_IMM: begin
        use_rd = 1'b1; use_rs1 = 1'b1;
        dec_next.reg_write = 1'b1;
        dec_next.alu_src   = 1'b1;
        dec_next.alu_op    = f3_alu(f3);
        dec_next.imm       = imm_i;
        if (f3 == 3'b001) begin
          dec_next.imm = imm_sh;
          if (f7 != 7'b0) illegal_next = 1'b1;
        end else if (f3 == 3'b101) begin
          dec_next.imm = imm_sh;
          if (f7 == F7_ALT) dec_next.alu_op = ALU_SRA;
          else if (f7 != 7'b0) illegal_next = 1'b1;
        end
      end
      OP_LOAD: begin
        use_rd = 1'b1; use_rs1 = 1'b1;
        dec_next.alu_src   = 1'b1;
        dec_next.mem_read  = 1'b1;
        dec_next.reg_write = 1'b1;
        dec_next.imm       = imm_i;
        dec_next.lsu_op    = f3;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) illegal_next = 1'b1;
      end
      OP_STORE: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        dec_next.alu_src   = 1'b1;
        dec_next.mem_write = 1'b1;
        dec_next.imm       = imm_s;
        dec_next.lsu_op    = f3;
        if (f3 > 3'b010) illegal_next = 1'b1;
      end
      OP_BRANCH: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        dec_next.branch = 1'b1;
        dec_next.br_op  = f3;
        dec_next.alu_op = ALU_SUB;
        dec_next.imm    = imm_b;
        if (f3 == 3'b010 || f3 == 3'b011) illegal_next = 1'b1;
      end
      OP_JAL: begin
        use_rd = 1'b1;
        dec_next.jal       = 1'b1;
        dec_next.reg_write = 1'b1;
        dec_next.pc_src    = 1'b1;
        dec_next.imm       = imm_j;
      end
      OP_JALR: begin
        use_rd = 1'b1; use_rs1 = 1'b1;
        dec_next.jalr      = 1'b1;
        dec_next.reg_write = 1'b1;
        dec_next.alu_src   = 1'b1;
        dec_next.imm       = imm_i;
        if (f3 != 3'b000) illegal_next = 1'b1;
      end
      OP_LUI: begin
        use_rd = 1'b1;
        dec_next.reg_write = 1'b1;
        dec_next.alu_src   = 1'b1;
        dec_next.imm       = imm_u;
        dec_next.rs1       = '0;
      end
      OP_AUIPC: begin
        use_rd = 1'b1;
        dec_next.reg_write = 1'b1;
        dec_next.alu_src   = 1'b1;
        dec_next.pc_src    = 1'b1;
        dec_next.imm       = imm_u;
      end
      OP_MISC:   if (f3 > 3'b001) illegal_next = 1'b1;
      OP_SYSTEM: if (f3 != 3'b000) illegal_next = 1'b1;
      // All valid opcodes end in 2'b11, so compressed words land here too.
      default:   illegal_next = 1'b1;
    endcase
    if (REG_AW < 5) begin
      if ((use_rd && inst[11]) || (use_rs1 && inst[19]) || (use_rs2 && inst[24]))
        illegal_next = 1'b1;
    end
    dec_next.illegal = illegal_next;
    if (illegal_next) begin
      dec_next.reg_write = 1'b0;
      dec_next.mem_read  = 1'b0;
      dec_next.mem_write = 1'b0;
      dec_next.branch    = 1'b0;
      dec_next.jal       = 1'b0;
      dec_next.jalr      = 1'b0;
      dec_next.lsu_op    = LSU_NONE;
    end
  end

  entry_t          mem_reg [DEPTH];
  logic [PW-1:0]   head_reg, tail_reg;
  logic [CW-1:0]   count_reg;
  logic            push, pop;

  // in_ready depends on count only, so out_ready never reaches fetch combinationally.
  assign bus.in_ready  = (count_reg < CW'(DEPTH));
  assign bus.out_valid = (count_reg != '0);
  assign push = bus.in_valid && bus.in_ready && !bus.flush;
  assign pop  = bus.out_valid && bus.out_ready && !bus.flush;

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      count_reg <= '0;
      head_reg  <= '0;
      tail_reg  <= '0;
    end else begin
      if (push) tail_reg <= ptr_inc(tail_reg);
      if (pop)  head_reg <= ptr_inc(head_reg);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) begin
        mem_reg[i]        <= '0;
        mem_reg[i].lsu_op <= LSU_NONE;
      end else if (push && tail_reg == PW'(i)) begin
        mem_reg[i] <= dec_next;
      end
    end
  end

  entry_t head;
  assign head = mem_reg[head_reg];

  assign bus.out_pc        = head.pc;
  assign bus.out_rd        = head.rd;
  assign bus.out_rs1       = head.rs1;
  assign bus.out_rs2       = head.rs2;
  assign bus.out_imm       = head.imm;
  assign bus.out_alu_op    = head.alu_op;
  assign bus.out_lsu_op    = head.lsu_op;
  assign bus.out_br_op     = head.br_op;
  assign bus.out_reg_write = head.reg_write;
  assign bus.out_mem_read  = head.mem_read;
  assign bus.out_mem_write = head.mem_write;
  assign bus.out_branch    = head.branch;
  assign bus.out_jal       = head.jal;
  assign bus.out_jalr      = head.jalr;
  assign bus.out_alu_src   = head.alu_src;
  assign bus.out_pc_src    = head.pc_src;
  assign bus.out_illegal   = head.illegal;
endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage: an RV32I instance (REG_AW=5) and an
// RV32E instance (REG_AW=4), both DEPTH=2, sharing clock and reset.
module tb_rv_decode_stage;
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_SRA = 4'd7;
  localparam logic [2:0] LSU_LW  = 3'd2;
  localparam logic [2:0] LSU_SW  = 3'd2;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  rv_decode_stage_if #(.REG_AW(5), .XLEN(32)) bus5 ();
  rv_decode_stage_if #(.REG_AW(4), .XLEN(32)) bus4 ();

  rv_decode_stage #(.REG_AW(5), .DEPTH(2), .XLEN(32)) u_dut5 (.clk(clk), .rst(rst), .bus(bus5));
  rv_decode_stage #(.REG_AW(4), .DEPTH(2), .XLEN(32)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive5(input logic [31:0] inst, input logic [31:0] pc);
    bus5.in_valid = 1'b1;
    bus5.in_inst  = inst;
    bus5.in_pc    = pc;
    $display("push rv32i inst=%08h pc=%08h", inst, pc);
  endtask

  task automatic drive4(input logic [31:0] inst, input logic [31:0] pc);
    bus4.in_valid = 1'b1;
    bus4.in_inst  = inst;
    bus4.in_pc    = pc;
    $display("push rv32e inst=%08h pc=%08h", inst, pc);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus5.flush = 1'b0; bus5.in_valid = 1'b0; bus5.in_inst = '0; bus5.in_pc = '0; bus5.out_ready = 1'b0;
    bus4.flush = 1'b0; bus4.in_valid = 1'b0; bus4.in_inst = '0; bus4.in_pc = '0; bus4.out_ready = 1'b0;
    step(); step();
    n_checks++; if (bus5.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus5.out_valid); end
    n_checks++; if (bus5.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus5.in_ready); end
    n_checks++; if (bus5.out_lsu_op !== 3'b111) begin n_fail++; $display("FAIL reset_lsu_op: got %b expected 111", bus5.out_lsu_op); end
    n_checks++; if ({bus5.out_pc, bus5.out_rd, bus5.out_rs1, bus5.out_rs2, bus5.out_imm, bus5.out_alu_op, bus5.out_br_op} !== '0)
      begin n_fail++; $display("FAIL reset_data: pc=%h rd=%0d imm=%h alu=%0d expected all 0", bus5.out_pc, bus5.out_rd, bus5.out_imm, bus5.out_alu_op); end
    n_checks++; if ({bus5.out_reg_write, bus5.out_mem_read, bus5.out_mem_write, bus5.out_branch, bus5.out_jal,
                     bus5.out_jalr, bus5.out_alu_src, bus5.out_pc_src, bus5.out_illegal} !== 9'b0)
      begin n_fail++; $display("FAIL reset_flags: got nonzero control flags, expected 0"); end
    n_checks++; if ({bus4.out_valid, bus4.in_ready} !== 2'b01) begin n_fail++; $display("FAIL reset_rv32e: valid/ready=%b expected 01", {bus4.out_valid, bus4.in_ready}); end
    rst = 1'b0;
  endtask

  task automatic test_addi();
    bus5.out_ready = 1'b1;
    drive5(32'h00500093, 32'h0);
    step();
    bus5.in_valid = 1'b0;
    n_checks++; if (bus5.out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid: got %b expected 1", bus5.out_valid); end
    n_checks++; if ({bus5.out_rd, bus5.out_rs1} !== {5'd1, 5'd0}) begin n_fail++; $display("FAIL addi_regs: rd=%0d rs1=%0d expected 1 0", bus5.out_rd, bus5.out_rs1); end
    n_checks++; if (bus5.out_imm !== 32'd5) begin n_fail++; $display("FAIL addi_imm: got %h expected 5", bus5.out_imm); end
    n_checks++; if (bus5.out_alu_op !== ALU_ADD) begin n_fail++; $display("FAIL addi_alu: got %0d expected %0d", bus5.out_alu_op, ALU_ADD); end
    n_checks++; if ({bus5.out_alu_src, bus5.out_reg_write, bus5.out_illegal, bus5.out_mem_write} !== 4'b1100)
      begin n_fail++; $display("FAIL addi_ctrl: src/wr/ill/mw=%b expected 1100", {bus5.out_alu_src, bus5.out_reg_write, bus5.out_illegal, bus5.out_mem_write}); end
    n_checks++; if (bus5.out_lsu_op !== 3'b111) begin n_fail++; $display("FAIL addi_lsu: got %b expected 111", bus5.out_lsu_op); end
    step();
    n_checks++; if (bus5.out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drain: out_valid=%b expected 0", bus5.out_valid); end
  endtask

  task automatic test_sub_sw();
    bus5.out_ready = 1'b1;
    drive5(32'h40208133, 32'h10);
    step();
    drive5(32'h0020A423, 32'h14);
    n_checks++; if (bus5.out_alu_op !== ALU_SUB) begin n_fail++; $display("FAIL sub_alu: got %0d expected %0d", bus5.out_alu_op, ALU_SUB); end
    n_checks++; if ({bus5.out_alu_src, bus5.out_reg_write} !== 2'b01) begin n_fail++; $display("FAIL sub_ctrl: src/wr=%b expected 01", {bus5.out_alu_src, bus5.out_reg_write}); end
    n_checks++; if ({bus5.out_rd, bus5.out_rs1, bus5.out_rs2} !== {5'd2, 5'd1, 5'd2})
      begin n_fail++; $display("FAIL sub_regs: rd=%0d rs1=%0d rs2=%0d expected 2 1 2", bus5.out_rd, bus5.out_rs1, bus5.out_rs2); end
    step();
    bus5.in_valid = 1'b0;
    n_checks++; if ({bus5.out_mem_write, bus5.out_reg_write, bus5.out_mem_read} !== 3'b100)
      begin n_fail++; $display("FAIL sw_ctrl: mw/wr/mr=%b expected 100", {bus5.out_mem_write, bus5.out_reg_write, bus5.out_mem_read}); end
    n_checks++; if (bus5.out_lsu_op !== LSU_SW) begin n_fail++; $display("FAIL sw_lsu: got %0d expected %0d", bus5.out_lsu_op, LSU_SW); end
    n_checks++; if (bus5.out_imm !== 32'd8) begin n_fail++; $display("FAIL sw_imm: got %h expected 8", bus5.out_imm); end
    n_checks++; if (bus5.out_pc !== 32'h14) begin n_fail++; $display("FAIL sw_pc: got %h expected 14", bus5.out_pc); end
    step();
  endtask

  task automatic test_branch_jal();
    bus5.out_ready = 1'b1;
    drive5(32'hFE000EE3, 32'h100);
    step();
    drive5(32'h010000EF, 32'h104);
    n_checks++; if ({bus5.out_branch, bus5.out_br_op, bus5.out_alu_op} !== {1'b1, 3'd0, ALU_SUB})
      begin n_fail++; $display("FAIL beq_ctrl: branch=%b br_op=%0d alu=%0d expected 1 0 1", bus5.out_branch, bus5.out_br_op, bus5.out_alu_op); end
    n_checks++; if (bus5.out_imm !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL beq_imm: got %h expected fffffffc", bus5.out_imm); end
    n_checks++; if (bus5.out_pc !== 32'h100) begin n_fail++; $display("FAIL beq_pc: got %h expected 100", bus5.out_pc); end
    step();
    bus5.in_valid = 1'b0;
    n_checks++; if ({bus5.out_jal, bus5.out_pc_src, bus5.out_reg_write, bus5.out_branch} !== 4'b1110)
      begin n_fail++; $display("FAIL jal_ctrl: jal/pcsrc/wr/br=%b expected 1110", {bus5.out_jal, bus5.out_pc_src, bus5.out_reg_write, bus5.out_branch}); end
    n_checks++; if ({bus5.out_rd, bus5.out_imm} !== {5'd1, 32'd16}) begin n_fail++; $display("FAIL jal_rd_imm: rd=%0d imm=%h expected 1 10", bus5.out_rd, bus5.out_imm); end
    step();
  endtask

  task automatic test_misc_decode();
    bus5.out_ready = 1'b1;
    drive5(32'h4020D093, 32'h200);             // srai x1,x1,2
    step();
    drive5(32'h40209093, 32'h204);             // slli with funct7=0100000
    n_checks++; if ({bus5.out_alu_op, bus5.out_imm, bus5.out_illegal} !== {ALU_SRA, 32'd2, 1'b0})
      begin n_fail++; $display("FAIL srai: alu=%0d imm=%h ill=%b expected 7 2 0", bus5.out_alu_op, bus5.out_imm, bus5.out_illegal); end
    step();
    drive5(32'h00C12283, 32'h208);             // lw x5,12(x2)
    n_checks++; if ({bus5.out_illegal, bus5.out_reg_write} !== 2'b10) begin n_fail++; $display("FAIL slli_bad: ill/wr=%b expected 10", {bus5.out_illegal, bus5.out_reg_write}); end
    step();
    drive5(32'h00000073, 32'h20C);             // ecall
    n_checks++; if ({bus5.out_mem_read, bus5.out_reg_write, bus5.out_lsu_op, bus5.out_imm, bus5.out_rd} !== {2'b11, LSU_LW, 32'd12, 5'd5})
      begin n_fail++; $display("FAIL lw: mr/wr=%b lsu=%0d imm=%h rd=%0d expected 11 2 c 5", {bus5.out_mem_read, bus5.out_reg_write}, bus5.out_lsu_op, bus5.out_imm, bus5.out_rd); end
    step();
    drive5(32'h00001073, 32'h210);             // csrrw: not supported
    n_checks++; if ({bus5.out_illegal, bus5.out_reg_write, bus5.out_lsu_op} !== {2'b00, 3'b111})
      begin n_fail++; $display("FAIL ecall: ill/wr=%b lsu=%b expected 00 111", {bus5.out_illegal, bus5.out_reg_write}, bus5.out_lsu_op); end
    step();
    bus5.in_valid = 1'b0;
    n_checks++; if (bus5.out_illegal !== 1'b1) begin n_fail++; $display("FAIL csr_illegal: got %b expected 1", bus5.out_illegal); end
    step();
  endtask

  task automatic test_back_to_back();
    bus5.out_ready = 1'b0;
    drive5(32'h00100093, 32'h300);
    n_checks++; if (bus5.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready0: got %b expected 1", bus5.in_ready); end
    step();
    drive5(32'h00200113, 32'h304);
    n_checks++; if ({bus5.in_ready, bus5.out_valid, bus5.out_rd} !== {2'b11, 5'd1}) begin n_fail++; $display("FAIL b2b_one: rdy/val=%b rd=%0d expected 11 1", {bus5.in_ready, bus5.out_valid}, bus5.out_rd); end
    step();
    drive5(32'h00300193, 32'h308);
    n_checks++; if (bus5.in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_full: in_ready=%b expected 0", bus5.in_ready); end
    step();
    n_checks++; if ({bus5.in_ready, bus5.out_rd, bus5.out_imm} !== {1'b0, 5'd1, 32'd1})
      begin n_fail++; $display("FAIL b2b_hold: rdy=%b rd=%0d imm=%h expected 0 1 1", bus5.in_ready, bus5.out_rd, bus5.out_imm); end
    bus5.out_ready = 1'b1;
    step();
    n_checks++; if ({bus5.out_valid, bus5.out_rd, bus5.out_imm, bus5.in_ready} !== {1'b1, 5'd2, 32'd2, 1'b1})
      begin n_fail++; $display("FAIL b2b_second: val=%b rd=%0d imm=%h rdy=%b expected 1 2 2 1", bus5.out_valid, bus5.out_rd, bus5.out_imm, bus5.in_ready); end
    step();
    bus5.in_valid = 1'b0;
    n_checks++; if ({bus5.out_valid, bus5.out_rd, bus5.out_pc} !== {1'b1, 5'd3, 32'h308})
      begin n_fail++; $display("FAIL b2b_third: val=%b rd=%0d pc=%h expected 1 3 308", bus5.out_valid, bus5.out_rd, bus5.out_pc); end
    step();
    n_checks++; if (bus5.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: out_valid=%b expected 0", bus5.out_valid); end
  endtask

  task automatic test_flush();
    bus5.out_ready = 1'b0;
    drive5(32'h00100093, 32'h400);
    step();
    drive5(32'h00200113, 32'h404);
    step();
    bus5.flush = 1'b1;
    drive5(32'h00300193, 32'h408);
    step();
    bus5.flush = 1'b0;
    bus5.in_valid = 1'b0;
    n_checks++; if ({bus5.out_valid, bus5.in_ready} !== 2'b01) begin n_fail++; $display("FAIL flush_full: val/rdy=%b expected 01", {bus5.out_valid, bus5.in_ready}); end
    step();
    n_checks++; if (bus5.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop: out_valid=%b expected 0", bus5.out_valid); end
    drive5(32'h00400213, 32'h40C);
    step();
    bus5.flush = 1'b1;
    drive5(32'h00500293, 32'h410);
    step();
    bus5.flush = 1'b0;
    bus5.in_valid = 1'b0;
    step();
    n_checks++; if (bus5.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_one: out_valid=%b expected 0", bus5.out_valid); end
    drive5(32'h00600313, 32'h414);
    step();
    bus5.in_valid = 1'b0;
    n_checks++; if ({bus5.out_valid, bus5.out_rd, bus5.out_pc} !== {1'b1, 5'd6, 32'h414})
      begin n_fail++; $display("FAIL flush_refill: val=%b rd=%0d pc=%h expected 1 6 414", bus5.out_valid, bus5.out_rd, bus5.out_pc); end
    drive5(32'h0020A423, 32'h418);
    step();
    bus5.in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++; if ({bus5.out_valid, bus5.in_ready, bus5.out_lsu_op, bus5.out_imm} !== {2'b01, 3'b111, 32'd0})
      begin n_fail++; $display("FAIL rst_mid: val/rdy=%b lsu=%b imm=%h expected 01 111 0", {bus5.out_valid, bus5.in_ready}, bus5.out_lsu_op, bus5.out_imm); end
  endtask

  task automatic test_rv32e();
    bus4.out_ready = 1'b1;
    drive4(32'h01000833, 32'h500);
    step();
    drive4(32'hFFFFFFFF, 32'h504);
    n_checks++; if ({bus4.out_valid, bus4.out_illegal, bus4.out_reg_write} !== 3'b110)
      begin n_fail++; $display("FAIL e_add_x16: val/ill/wr=%b expected 110", {bus4.out_valid, bus4.out_illegal, bus4.out_reg_write}); end
    step();
    drive4(32'h00500093, 32'h508);
    n_checks++; if ({bus4.out_illegal, bus4.out_lsu_op} !== {1'b1, 3'b111}) begin n_fail++; $display("FAIL e_ones: ill=%b lsu=%b expected 1 111", bus4.out_illegal, bus4.out_lsu_op); end
    step();
    bus4.in_valid = 1'b0;
    n_checks++; if ({bus4.out_illegal, bus4.out_rd, bus4.out_reg_write} !== {1'b0, 4'd1, 1'b1})
      begin n_fail++; $display("FAIL e_addi: ill=%b rd=%0d wr=%b expected 0 1 1", bus4.out_illegal, bus4.out_rd, bus4.out_reg_write); end
    bus5.out_ready = 1'b1;
    drive5(32'h01000833, 32'h600);
    step();
    bus5.in_valid = 1'b0;
    n_checks++; if ({bus5.out_illegal, bus5.out_reg_write, bus5.out_rd, bus5.out_rs2} !== {2'b01, 5'd16, 5'd16})
      begin n_fail++; $display("FAIL i_add_x16: ill/wr=%b rd=%0d rs2=%0d expected 01 16 16", {bus5.out_illegal, bus5.out_reg_write}, bus5.out_rd, bus5.out_rs2); end
    step();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_sub_sw();
    test_branch_jal();
    test_misc_decode();
    test_back_to_back();
    test_flush();
    test_rv32e();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rv_decode_stage.md
Name: rv_decode_stage

Overview:
- Registered RV32I/RV32E instruction decode stage between fetch and execute; successor to the combinational field decoder.
- Produces a full control bundle: ALU, LSU, branch, jump, immediate select and illegal-instruction flag.
- Decoded results are buffered in a DEPTH-entry output queue with valid/ready handshakes on both sides, plus a flush input for redirects.
- Reuses the existing ALU_* and LSU_* opcode encodings.

Parameters:
- REG_AW, 5, register index width; 5 = RV32I (x0-x31), 4 = RV32E (x0-x15).
- DEPTH, 2, output buffer entries, 1 or 2; 2 gives full throughput under out_ready.
- XLEN, 32, PC width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  drop all buffered entries and the current input.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage accepts an instruction this cycle.
- in_inst  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  head entry valid.
- out_ready  in  1  execute consumes the head entry.
- out_pc  out  XLEN  PC of the head entry.
- out_rd, out_rs1, out_rs2  out  REG_AW each  register indices (low REG_AW bits of the fields).
- out_imm  out  32  selected, sign-extended immediate (I/S/B/U/J).
- out_alu_op  out  4  ALU_* code.
- out_lsu_op  out  3  LSU_* code; 3'b111 for non-memory instructions.
- out_br_op  out  3  funct3 of a branch; 0 otherwise.
- out_reg_write, out_mem_read, out_mem_write, out_branch, out_jal, out_jalr, out_alu_src, out_pc_src  out  1 each  control flags; out_pc_src=1 means ALU operand A is the PC (auipc, jal).
- out_illegal  out  1  instruction not legal for the configuration.

Behaviour:
- Reset:
  - count=0, out_valid=0, in_ready=1.
  - All out_* data fields read 0; out_lsu_op reads 3'b111.
- Push and pop:
  - Push when in_valid && in_ready && !flush.
  - Pop when out_valid && out_ready && !flush.
  - in_ready = (count < DEPTH), from registered state only; no combinational path from out_ready.
  - Latency is 1 cycle: an instruction accepted in cycle N is at the head in N+1 if the queue was empty.
  - Simultaneous push and pop leave count unchanged and keep order (FIFO).
  - Head outputs stay stable while out_valid && !out_ready.
- Flush:
  - Next cycle count=0 and out_valid=0.
  - Same-cycle input is discarded.
  - Flush has priority over push and pop; rst has priority over flush.
- Decode, combinational on in_inst, registered on push:
  - R-type: alu_op from funct3 and funct7 (SUB/SRA when funct7=0100000); reg_write=1.
  - OP-IMM: alu_src=1, reg_write=1; SLLI/SRLI/SRAI use imm[4:0].
  - LOAD: alu_src=1, mem_read=1, reg_write=1, alu_op=ALU_ADD, imm_i.
  - STORE: alu_src=1, mem_write=1, alu_op=ALU_ADD, imm_s.
  - BRANCH: branch=1, br_op=funct3, alu_op=ALU_SUB, imm_b = {inst[31],inst[7],inst[30:25],inst[11:8],0} sign-extended.
  - JAL: jal=1, reg_write=1, pc_src=1, imm_j = {inst[31],inst[19:12],inst[20],inst[30:21],0} sign-extended.
  - JALR (funct3=000): jalr=1, reg_write=1, alu_src=1, imm_i.
  - LUI: reg_write=1, alu_src=1, imm_u; rs1 forced to 0.
  - AUIPC: reg_write=1, alu_src=1, pc_src=1, imm_u.
  - FENCE/FENCE.I, ECALL/EBREAK: legal, all controls 0. CSR funct3 values: illegal in this generation.
- Illegal when any of:
  - unknown opcode or inst[1:0] != 2'b11;
  - undefined funct3 for LOAD, STORE, BRANCH or JALR;
  - funct7 not 0000000 for R-type, or not 0000000/0100000 for SUB and SRA/SRL, or not 0000000/0100000 for SRLI/SRAI (SLLI requires 0000000);
  - REG_AW=4 and bit 4 of any used rd, rs1 or rs2 field set.
- Illegal entries are still pushed with out_illegal=1. On those entries reg_write, mem_read, mem_write, branch, jal and jalr are forced to 0 and lsu_op to 3'b111.

Test Plan:
- rst then 0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle: out_valid=1, rd=1, rs1=0, imm=5, alu_op=ALU_ADD, alu_src=1, reg_write=1, illegal=0.
- 0x40208133 (sub x2,x1,x2), then 0x0020A423 (sw x2,8(x1)) -> first: ALU_SUB, alu_src=0, reg_write=1; second: mem_write=1, lsu_op=LSU_SW, imm=8, reg_write=0.
- 0xFE000EE3 (beq x0,x0,-4) at pc 0x100, then 0x010000EF (jal x1,16) -> first: branch=1, br_op=0, imm=0xFFFFFFFC; second: jal=1, rd=1, imm=16, pc_src=1.
- out_ready=0, push 3 back-to-back with DEPTH=2 -> in_ready=0 after 2 accepted, third held. Release out_ready -> order preserved, no loss, no duplication.
- 2 entries buffered, assert flush together with in_valid -> next cycle out_valid=0, count=0, new input dropped. rst asserted mid-stream -> same empty state, out_lsu_op=3'b111.
- REG_AW=4: 0x01000833 (add x16,x0,x16) -> illegal=1, reg_write=0. 0xFFFFFFFF -> illegal=1. With REG_AW=5 the first word is legal.
